// File: rtl/shift_add_multiplier_pkg.sv
// ============================================================================
// Module   : shift_add_multiplier_pkg
// Brief    : Shared state encoding and default width for the shift-add multiplier
// Revision : 1.0
// ============================================================================
`default_nettype none

package shift_add_multiplier_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_add_multiplier_if.sv
// ============================================================================
// Module   : shift_add_multiplier_if
// Brief    : Start/done request bus between control logic and the multiplier
// Revision : 1.0
// ============================================================================
`default_nettype none

interface shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, product
  );
endinterface

`default_nettype wire

// File: rtl/shift_add_multiplier_adder_rc8.sv
// ============================================================================
// Module   : adder_rc8
// Brief    : Combinational ripple-carry adder built from per-bit full adders
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder_rc8 #(
  parameter int WIDTH = 8
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cout,
  output logic [WIDTH-1:0] s
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      assign s[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
// ============================================================================
// Module   : shift_add_multiplier
// Brief    : Sequential unsigned radix-2 shift-and-add multiplier, one bit/clock
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_add_multiplier_if.slave bus
);

  localparam int              CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t               state;
  logic [WIDTH-1:0]     m;
  logic [2*WIDTH-1:0]   p;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   result;

  logic                 add_cout;
  logic [WIDTH-1:0]     add_sum;
  logic [2*WIDTH-1:0]   p_next;

  adder_rc8 #(.WIDTH(WIDTH)) u_adder (
    .cin  (1'b0),
    .a    (p[2*WIDTH-1:WIDTH]),
    .b    (m),
    .cout (add_cout),
    .s    (add_sum)
  );

  // Carry-out becomes the new MSB, so the shifted partial product never loses a bit.
  always_comb begin
    p_next = {1'b0, p[2*WIDTH-1:1]};
    if (p[0]) begin
      p_next = {add_cout, add_sum, p[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      m      <= '0;
      p      <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            m     <= bus.a;
            p     <= {{WIDTH{1'b0}}, bus.b};
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= p_next;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready   = (state == IDLE) || (state == DONE);
  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = result;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// ============================================================================
// Module   : tb_shift_add_multiplier
// Brief    : Directed vector table plus handshake corner sequences for the multiplier
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shift_add_multiplier;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  shift_add_multiplier_if #(.WIDTH(8)) bus ();

  shift_add_multiplier #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one product; a/b are scrambled after acceptance, latency/busy/stability checked.
  task automatic run_one(input logic [7:0] va, input logic [7:0] vb,
                         input logic [15:0] exp, input string nm);
    int          k;
    int          busy_cnt;
    bit          stable;
    logic [15:0] held;
    k = 0;
    while (!bus.ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    check({nm, " ready"}, 32'(bus.ready), 32'd1);
    held      = bus.product;
    bus.start = 1'b1;
    bus.a     = va;
    bus.b     = vb;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    k         = 1;
    busy_cnt  = 0;
    stable    = 1'b1;
    while (!bus.done && k < 20) begin
      if (bus.busy) busy_cnt++;
      if (bus.product !== held) stable = 1'b0;
      @(negedge clk);
      k++;
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
    end
    check({nm, " latency"}, 32'(k), 32'd9);
    check({nm, " busy_cycles"}, 32'(busy_cnt), 32'd8);
    check({nm, " product_stable"}, 32'(stable), 32'd1);
    check({nm, " product"}, 32'(bus.product), 32'(exp));
    @(negedge clk);
    check({nm, " done_width"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int          k;
    int          done_cnt;
    bit          stable;
    logic [7:0]  sa;
    logic [7:0]  sb;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0]  = '{8'd13,  8'd11,  16'h008F};
    vecs[1]  = '{8'hFF,  8'hFF,  16'hFE01};
    vecs[2]  = '{8'h00,  8'hA5,  16'h0000};
    vecs[3]  = '{8'hA5,  8'h00,  16'h0000};
    vecs[4]  = '{8'h01,  8'hFF,  16'h00FF};
    vecs[5]  = '{8'h80,  8'h02,  16'h0100};
    vecs[6]  = '{8'h0F,  8'h0F,  16'h00E1};
    vecs[7]  = '{8'hAA,  8'h55,  16'h3872};
    vecs[8]  = '{8'h80,  8'h80,  16'h4000};
    vecs[9]  = '{8'h05,  8'h07,  16'h0023};
    vecs[10] = '{8'hFF,  8'h01,  16'h00FF};

    repeat (2) @(negedge clk);
    check("reset ready", 32'(bus.ready), 32'd1);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset product", 32'(bus.product), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // Back-to-back: start held high, new operands presented in the DONE cycle.
    bus.start = 1'b1;
    bus.a     = 8'd2;
    bus.b     = 8'd3;
    @(negedge clk);
    k = 1;
    while (!bus.done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b2b first latency", 32'(k), 32'd9);
    check("b2b first product", 32'(bus.product), 32'h0006);
    bus.a = 8'h10;
    bus.b = 8'h10;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b no bubble busy", 32'(bus.busy), 32'd1);
    check("b2b no bubble ready", 32'(bus.ready), 32'd0);
    k      = 1;
    stable = 1'b1;
    while (!bus.done && k < 20) begin
      if (bus.product !== 16'h0006) stable = 1'b0;
      @(negedge clk);
      k++;
    end
    check("b2b first held", 32'(stable), 32'd1);
    check("b2b second latency", 32'(k), 32'd9);
    check("b2b second product", 32'(bus.product), 32'h0100);
    @(negedge clk);

    // Start pulses while busy must be ignored.
    bus.start = 1'b1;
    bus.a     = 8'd5;
    bus.b     = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    done_cnt  = 0;
    for (int c = 1; c <= 16; c++) begin
      if (bus.done) done_cnt++;
      bus.start = (c >= 2 && c <= 5);
      bus.a     = 8'h77 + 8'(c);
      bus.b     = 8'h77 - 8'(c);
      @(negedge clk);
    end
    check("midrun done count", 32'(done_cnt), 32'd1);
    check("midrun product", 32'(bus.product), 32'h0023);

    // Asynchronous reset between edges during RUN.
    bus.start = 1'b1;
    bus.a     = 8'd13;
    bus.b     = 8'd11;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst product", 32'(bus.product), 32'd0);
    check("async rst busy", 32'(bus.busy), 32'd0);
    check("async rst done", 32'(bus.done), 32'd0);
    check("async rst ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("post rst no done", 32'(done_cnt), 32'd0);
    check("post rst product", 32'(bus.product), 32'd0);
    run_one(8'd13, 8'd11, 16'h008F, "post rst");

    // Grid sweep including both operand extremes.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        sa = 8'(i * 17);
        sb = 8'(j * 17);
        run_one(sa, sb, 16'(sa) * 16'(sb), $sformatf("sweep %0d*%0d", sa, sb));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
